sram_sp_init: RTL

- Parametrised single-port masked SRAM for cache data/tag arrays and scratch memories.
- Successor to the fixed-geometry per-array macros: width, depth, mask granularity and read latency are generic.
- Adds a hardware initialisation sweep after reset or on request, and a req/gnt/rvalid handshake.
- Instantiated directly by caches and by the FPGA/ASIC memory wrappers.

---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_array_core.sv | 97 +++++++++
 rtl/sram_sp_init.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_sp_init single-port memory.
// The SRAM_PARITY_EN build uses seg_parity to generate and check per-segment parity.
package sram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_e;

    // Widest mask segment seg_parity can cover; callers zero-extend into it.
    localparam int SEG_MAX_W = 64;

    function automatic int calc_num_seg(input int data_width, input int mask_gran);
        return data_width / mask_gran;
    endfunction

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic seg_parity(input logic [SEG_MAX_W-1:0] seg);
        return ^seg;
    endfunction

endpackage

// File: rtl/sram_array_core.sv
// Behavioural masked storage array with a registered read port.
// Technology wrappers replace this module. Parity columns exist only when SRAM_PARITY_EN is defined.
module sram_array_core
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int MASK_GRAN  = 8,
    parameter int NUM_SEG    = calc_num_seg(DATA_WIDTH, MASK_GRAN),
    parameter int ADDR_W     = calc_addr_w(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [NUM_SEG-1:0]    i_mask,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
`ifdef SRAM_PARITY_EN
    ,
    output logic [NUM_SEG-1:0]    o_rpar
`endif
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_in_range;

    // Addresses past the last word occur only when DEPTH is not a power of two.
    assign w_in_range = ({1'b0, i_addr} < DEPTH_W);

    // Masked write of the enabled segments of an in-range word.
    always_ff @(posedge i_clk) begin
        if (i_we && w_in_range) begin
            for (int s = 0; s < NUM_SEG; s++) begin
                if (i_mask[s]) begin
                    r_mem[i_addr][s*MASK_GRAN +: MASK_GRAN] <= i_wdata[s*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Read register: loads only on a read, so it holds between reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_in_range ? r_mem[i_addr] : '0;
        end
    end

    assign o_rdata = r_rdata;

`ifdef SRAM_PARITY_EN
    logic [NUM_SEG-1:0] r_par [DEPTH];
    logic [NUM_SEG-1:0] r_rpar;
    logic [NUM_SEG-1:0] w_wpar;

    if (MASK_GRAN > SEG_MAX_W) begin : g_bad_seg_w
        $error("sram_array_core: MASK_GRAN exceeds SEG_MAX_W for parity");
    end

    // Even parity of each incoming write segment.
    always_comb begin
        w_wpar = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            w_wpar[s] = seg_parity(SEG_MAX_W'(i_wdata[s*MASK_GRAN +: MASK_GRAN]));
        end
    end

    // Parity column write, masked exactly like the data columns.
    always_ff @(posedge i_clk) begin
        if (i_we && w_in_range) begin
            for (int s = 0; s < NUM_SEG; s++) begin
                if (i_mask[s]) begin
                    r_par[i_addr][s] <= w_wpar[s];
                end
            end
        end
    end

    // Parity read register; out-of-range reads return the parity of zero data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rpar <= '0;
        end else if (i_re) begin
            r_rpar <= w_in_range ? r_par[i_addr] : '0;
        end
    end

    assign o_rpar = r_rpar;
`endif

endmodule

// File: rtl/sram_sp_init.sv
// Parametrised single-port masked SRAM with a hardware init sweep and req/gnt/rvalid handshake.
// Optional per-segment parity checking is enabled by defining SRAM_PARITY_EN.
module sram_sp_init
    import sram_pkg::*;
#(
    parameter int                             DATA_WIDTH = 256,
    parameter int                             DEPTH      = 512,
    parameter int                             MASK_GRAN  = 8,
    parameter int                             OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0]          INIT_VALUE = '0
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            init_req_i,
    output logic                                            init_busy_o,
    input  logic                                            req_i,
    output logic                                            gnt_o,
    input  logic                                            we_i,
    input  logic [calc_addr_w(DEPTH)-1:0]                   addr_i,
    input  logic [calc_num_seg(DATA_WIDTH, MASK_GRAN)-1:0]  wmask_i,
    input  logic [DATA_WIDTH-1:0]                           wdata_i,
    output logic                                            rvalid_o,
    output logic [DATA_WIDTH-1:0]                           rdata_o,
    output logic                                            parity_err_o
);

    localparam int              NUM_SEG   = calc_num_seg(DATA_WIDTH, MASK_GRAN);
    localparam int              ADDR_W    = calc_addr_w(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
        $error("sram_sp_init: MASK_GRAN must divide DATA_WIDTH");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_sp_init: DEPTH must be at least 2");
    end
    if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_outreg
        $error("sram_sp_init: OUT_REG must be 0 or 1");
    end

    sram_state_e           r_state;
    logic [ADDR_W-1:0]     r_cnt;
    logic                  r_init_busy;
    logic                  r_rv1;

    logic                  w_ready;
    logic                  w_gnt;
    logic                  w_acc_rd;
    logic                  w_acc_wr;
    logic                  w_core_we;
    logic                  w_core_re;
    logic [ADDR_W-1:0]     w_core_addr;
    logic [NUM_SEG-1:0]    w_core_mask;
    logic [DATA_WIDTH-1:0] w_core_wdata;
    logic [DATA_WIDTH-1:0] w_core_rdata;
    logic                  w_par_mismatch;

    assign w_ready  = (r_state == READY);
    // A sweep request wins over an access presented in the same cycle.
    assign w_gnt    = req_i & w_ready & ~init_req_i;
    assign w_acc_rd = w_gnt & ~we_i;
    assign w_acc_wr = w_gnt & we_i;
    assign gnt_o    = w_gnt;
    assign init_busy_o = r_init_busy;

    // Sweep/ready state machine with the init address counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= READY;
                        r_cnt       <= '0;
                        r_init_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (init_req_i) begin
                        r_state     <= INIT;
                        r_cnt       <= '0;
                        r_init_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= INIT;
                    r_cnt       <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Array port steering: the sweep owns the port outside READY.
    always_comb begin
        w_core_we    = 1'b0;
        w_core_re    = 1'b0;
        w_core_addr  = addr_i;
        w_core_mask  = wmask_i;
        w_core_wdata = wdata_i;
        if (!w_ready) begin
            w_core_we    = 1'b1;
            w_core_addr  = r_cnt;
            w_core_mask  = '1;
            w_core_wdata = INIT_VALUE;
        end else begin
            w_core_we = w_acc_wr;
            w_core_re = w_acc_rd;
        end
    end

    // First stage of the read-valid pipeline, aligned with the array read register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rv1 <= 1'b0;
        end else begin
            r_rv1 <= w_acc_rd;
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NUM_SEG-1:0] w_core_rpar;
    logic [NUM_SEG-1:0] w_calc_par;

    // Recompute segment parity from the word coming out of the array.
    always_comb begin
        w_calc_par = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            w_calc_par[s] = seg_parity(SEG_MAX_W'(w_core_rdata[s*MASK_GRAN +: MASK_GRAN]));
        end
    end

    assign w_par_mismatch = |(w_calc_par ^ w_core_rpar);
`else
    assign w_par_mismatch = 1'b0;
`endif

    sram_array_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .MASK_GRAN  (MASK_GRAN),
        .NUM_SEG    (NUM_SEG),
        .ADDR_W     (ADDR_W)
    ) u_core (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_we    (w_core_we),
        .i_re    (w_core_re),
        .i_addr  (w_core_addr),
        .i_mask  (w_core_mask),
        .i_wdata (w_core_wdata),
        .o_rdata (w_core_rdata)
`ifdef SRAM_PARITY_EN
        ,
        .o_rpar  (w_core_rpar)
`endif
    );

    if (OUT_REG == 0) begin : g_out_direct
        assign rvalid_o     = r_rv1;
        assign rdata_o      = w_core_rdata;
        assign parity_err_o = r_rv1 & w_par_mismatch;
    end else begin : g_out_reg
        logic                  r_rv2;
        logic                  r_perr2;
        logic [DATA_WIDTH-1:0] r_rdata2;

        // Extra output stage; data loads only with a valid read so it holds otherwise.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rv2    <= 1'b0;
                r_perr2  <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_rv2   <= r_rv1;
                r_perr2 <= r_rv1 & w_par_mismatch;
                if (r_rv1) begin
                    r_rdata2 <= w_core_rdata;
                end
            end
        end

        assign rvalid_o     = r_rv2;
        assign rdata_o      = r_rdata2;
        assign parity_err_o = r_perr2;
    end

endmodule
